// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY side) with an emulated 32 x 16-bit register file.
// Bit-level handshake: the initiator presents md_i while MDC is low and it is sampled on the MDC rise; this responder drives md_o on the MDC fall.
module mdio_responder #(
  parameter int          PreambleLen = 32,
  parameter logic [15:0] PhyId1      = 16'h0141,
  parameter logic [15:0] PhyId2      = 16'h0CC2,
  parameter int          SyncStages  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  phy_addr_i,
  input  logic        mdc_i,
  input  logic        md_i,
  output logic        md_o,
  output logic        md_oe,
  output logic        busy_o,
  output logic        wr_valid_o,
  output logic [4:0]  wr_addr_o,
  output logic [15:0] wr_data_o
);

  localparam int              PreW   = $clog2(PreambleLen + 1);
  localparam logic [PreW-1:0] PreMax = PreW'(PreambleLen);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_RDATA = 3'd6,
    S_WDATA = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [SyncStages-1:0] r_mdc_sync;
  logic [SyncStages-1:0] r_md_sync;
  logic                  r_mdc_d;
  logic                  w_mdc_s;
  logic                  w_md;
  logic                  w_rise;
  logic                  w_fall;

  logic [PreW-1:0] r_pre_cnt;
  logic [4:0]      r_bit_cnt;
  logic [15:0]     r_shift;
  logic            r_is_read;
  logic [4:0]      r_regad;
  logic [15:0]     r_rdata;
  logic [15:0]     r_regs [32];

  logic [15:0] w_shift_in;
  logic [15:0] w_reg_val;
  logic        w_id_reg;
  logic        w_md_o_nxt;
  logic        w_md_oe_nxt;
  logic        w_commit;
  logic        w_rdata_load;
  logic        w_rdata_shift;

  // Synchronisers; edges come from the last synchronised sample and its delayed copy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mdc_sync <= '0;
      r_md_sync  <= '0;
      r_mdc_d    <= 1'b0;
    end else begin
      r_mdc_sync <= {r_mdc_sync[SyncStages-2:0], mdc_i};
      r_md_sync  <= {r_md_sync[SyncStages-2:0], md_i};
      r_mdc_d    <= w_mdc_s;
    end
  end

  assign w_mdc_s    = r_mdc_sync[SyncStages-1];
  assign w_md       = r_md_sync[SyncStages-1];
  assign w_rise     = w_mdc_s & ~r_mdc_d;
  assign w_fall     = ~w_mdc_s & r_mdc_d;
  assign w_shift_in = {r_shift[14:0], w_md};
  assign w_id_reg   = (r_regad == 5'd2) || (r_regad == 5'd3);
  assign busy_o     = (r_state != S_IDLE);

  always_comb begin
    w_reg_val = r_regs[w_shift_in[4:0]];
    if (w_shift_in[4:0] == 5'd2) w_reg_val = PhyId1;
    if (w_shift_in[4:0] == 5'd3) w_reg_val = PhyId2;
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise && !w_md && (r_pre_cnt == PreMax)) w_next_state = S_ST;
      end
      S_ST: begin
        if (w_rise) w_next_state = w_md ? S_OP : S_IDLE;
      end
      S_OP: begin
        if (w_rise && (r_bit_cnt == 5'd1)) begin
          if ((w_shift_in[1:0] == 2'b10) || (w_shift_in[1:0] == 2'b01)) w_next_state = S_PHYAD;
          else                                                         w_next_state = S_IDLE;
        end
      end
      S_PHYAD: begin
        if (w_rise && (r_bit_cnt == 5'd4)) begin
          w_next_state = (w_shift_in[4:0] == phy_addr_i) ? S_REGAD : S_IDLE;
        end
      end
      S_REGAD: begin
        if (w_rise && (r_bit_cnt == 5'd4)) w_next_state = S_TA;
      end
      S_TA: begin
        if (w_rise) begin
          if (r_is_read) begin
            if (r_bit_cnt == 5'd1) w_next_state = S_RDATA;
          end else if (r_bit_cnt == 5'd0) begin
            if (!w_md) w_next_state = S_IDLE;
          end else begin
            w_next_state = w_md ? S_IDLE : S_WDATA;
          end
        end
      end
      S_RDATA: begin
        if (w_fall && (r_bit_cnt == 5'd16)) w_next_state = S_IDLE;
      end
      S_WDATA: begin
        if (w_rise && (r_bit_cnt == 5'd15)) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: next pad values, write commit, read-data load/shift strobes
  always_comb begin
    w_md_o_nxt    = md_o;
    w_md_oe_nxt   = md_oe;
    w_commit      = 1'b0;
    w_rdata_load  = 1'b0;
    w_rdata_shift = 1'b0;
    case (r_state)
      S_REGAD: begin
        w_rdata_load = w_rise && (r_bit_cnt == 5'd4);
      end
      S_TA: begin
        if (r_is_read && w_fall && (r_bit_cnt == 5'd1)) begin
          w_md_oe_nxt = 1'b1;
          w_md_o_nxt  = 1'b0;
        end
      end
      S_RDATA: begin
        if (w_fall) begin
          if (r_bit_cnt == 5'd16) begin
            w_md_oe_nxt = 1'b0;
            w_md_o_nxt  = 1'b0;
          end else begin
            w_md_o_nxt    = r_rdata[15];
            w_rdata_shift = 1'b1;
          end
        end
      end
      S_WDATA: begin
        w_commit = w_rise && (r_bit_cnt == 5'd15) && !w_id_reg;
      end
      default: begin
        w_md_oe_nxt = 1'b0;
        w_md_o_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath: counters, shifter, register file, registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      md_o       <= 1'b0;
      md_oe      <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      r_pre_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_is_read  <= 1'b0;
      r_regad    <= '0;
      r_rdata    <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      md_o       <= w_md_o_nxt;
      md_oe      <= w_md_oe_nxt;
      wr_valid_o <= w_commit;
      if (w_commit) begin
        wr_addr_o        <= r_regad;
        wr_data_o        <= w_shift_in;
        r_regs[r_regad]  <= w_shift_in;
      end

      // The preamble count only lives in IDLE, so every frame needs its own preamble.
      if (r_state != S_IDLE) begin
        r_pre_cnt <= '0;
      end else if (w_rise) begin
        if (!w_md)                  r_pre_cnt <= '0;
        else if (r_pre_cnt != PreMax) r_pre_cnt <= r_pre_cnt + 1'b1;
      end

      if (w_rise) r_shift <= w_shift_in;

      if (w_next_state != r_state)             r_bit_cnt <= '0;
      else if (w_rise && (r_state != S_IDLE))  r_bit_cnt <= r_bit_cnt + 5'd1;

      if ((r_state == S_OP) && w_rise && (r_bit_cnt == 5'd1)) begin
        r_is_read <= (w_shift_in[1:0] == 2'b10);
      end

      if (w_rdata_load) begin
        r_regad <= w_shift_in[4:0];
        r_rdata <= w_reg_val;
      end else if (w_rdata_shift) begin
        r_rdata <= {r_rdata[14:0], 1'b0};
      end
    end
  end

endmodule
